// File: rtl/mips_multicycle_core.sv
// -----------------------------------------------------------------------------
// mips_multicycle_core
//   Multicycle MIPS-subset core with a single stallable memory port shared by
//   instruction fetch and data accesses. Register file and PC live inside.
//
// Parameters
//   RESET_PC       PC loaded on reset.
//   REG_RESET_CLR  1: all GPRs cleared on reset; 0: GPRs keep contents (r0
//                  always reads as zero either way).
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   mem_req    out  memory access request (FETCH / MEM states)
//   mem_we     out  1 = store, 0 = read
//   mem_addr   out  word-aligned byte address
//   mem_wdata  out  store data
//   mem_rdata  in   read data, valid when mem_req && mem_ready
//   mem_ready  in   transfer completes when mem_req && mem_ready
//   retire     out  one-cycle pulse per completed instruction
//   halted     out  core sits in HALT (sticky until rst)
//   pc_dbg     out  current PC
//
// Build option
//   MIPS_ILLEGAL_TRAP_EN  defined: unknown opcode/funct halts the core
//                         (pc left at faulting+4, no retire).
//                         undefined: unknown opcode/funct retires as a NOP.
// -----------------------------------------------------------------------------
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          REG_RESET_CLR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic        halted,
    output logic [31:0] pc_dbg
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        retire_q, retire_d;
    logic [31:0] rf_q [0:31];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] alu_res;
    logic        legal;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        unused_shamt;

    assign opcode       = ir_q[31:26];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign unused_shamt = ^ir_q[10:6];

    // ALU result and legality of the instruction currently in IR.
    always_comb begin
        alu_res = a_q + imm_q;
        legal   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    6'h20:   alu_res = a_q + b_q;
                    6'h22:   alu_res = a_q - b_q;
                    6'h24:   alu_res = a_q & b_q;
                    6'h25:   alu_res = a_q | b_q;
                    6'h2A:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                    default: legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        retire_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // r0 is forced to zero at the read side so it never needs storage.
                a_d   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
                b_d   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
                imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
                if (opcode == OP_J) begin
                    pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!legal) begin
`ifdef MIPS_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
`endif
                end else if (opcode == OP_BEQ) begin
                    // pc already points past the branch here.
                    if (a_q == b_q) pc_d = pc_q + (imm_q << 2);
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    alu_d   = alu_res;
                    state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            retire_q <= retire_d;
        end
    end

    // Write-back: rd for R-type, rt otherwise; r0 writes dropped here.
    assign rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
    assign rf_we    = (state_q == S_WB) && (rf_waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst && REG_RESET_CLR) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Bus outputs are decoded from state; rst masks them so an in-flight
    // request is dropped in the same cycle reset is seen.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == S_FETCH) begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end else if (state_q == S_MEM) begin
                mem_req  = 1'b1;
                mem_addr = {alu_q[31:2], 2'b00};
                if (opcode == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = b_q;
                end
            end
        end
    end

    assign retire = retire_q;
    assign halted = (state_q == S_HALT);
    assign pc_dbg = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_core
//   Directed program run on mips_multicycle_core (RESET_PC = 0x100) against a
//   small bench memory with programmable ready delay. Register results are made
//   visible by storing them and checking the store data on the bus.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

    int checks = 0;
    int errors = 0;

    // bench memory: program words plus a small store-backed data window
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:15];
    logic [15:0] dvalid = '0;
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int          stab_err = 0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        hold_we = 1'b0;

    mips_multicycle_core #(.RESET_PC(32'h100), .REG_RESET_CLR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .halted(halted), .pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && (wait_cnt >= wait_cycles);

    always_comb begin
        if (mem_addr < 32'h40 && dvalid[mem_addr[5:2]]) mem_rdata = dmem[mem_addr[5:2]];
        else                                            mem_rdata = imem[mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (mem_req && mem_ready && mem_we) begin
            dmem[mem_addr[5:2]]   <= mem_wdata;
            dvalid[mem_addr[5:2]] <= 1'b1;
            last_wr_addr          <= mem_addr;
            last_wr_data          <= mem_wdata;
            wr_cnt                <= wr_cnt + 1;
        end
        // request, direction and address must hold while a transfer waits
        if (hold_pending && !rst && (!mem_req || mem_addr !== hold_addr || mem_we !== hold_we))
            stab_err <= stab_err + 1;
        hold_pending <= mem_req && !mem_ready && !rst;
        hold_addr    <= mem_addr;
        hold_we      <= mem_we;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // wait for the next retire pulse; check latency and the address now being fetched
    task automatic step(input string tag, input int lat, input logic [31:0] nxt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (retire !== 1'b1 && n < 60);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_next"}, mem_addr, nxt);
        $display("step %s: latency %0d fetch_addr %h", tag, n, mem_addr);
    endtask

    task automatic chk_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_waddr"}, last_wr_addr, addr);
        chk({tag, "_wdata"}, last_wr_data, data);
    endtask

    initial begin
        int n, rcnt, reqs;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
        imem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // 0x100 ADDI r1,r0,5
        imem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);     // 0x104 ADDI r2,r0,-3
        imem[66] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);         // 0x108 ADD r3,r1,r2
        imem[67] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);         // 0x10C SLT r4,r2,r1
        imem[68] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);        // 0x110 SW r3,8(r0)
        imem[69] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);        // 0x114 LW r5,8(r0)
        imem[70] = enc_i(6'h2B, 5'd0, 5'd5, 16'd12);       // 0x118 SW r5,12(r0)
        imem[71] = enc_i(6'h2B, 5'd0, 5'd4, 16'd16);       // 0x11C SW r4,16(r0)
        imem[72] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);        // 0x120 ADDI r0,r0,7
        imem[73] = enc_r(5'd0, 5'd0, 5'd6, 6'h20);         // 0x124 ADD r6,r0,r0
        imem[74] = enc_i(6'h2B, 5'd0, 5'd6, 16'd20);       // 0x128 SW r6,20(r0)
        imem[75] = {6'h02, 26'h8};                         // 0x12C J -> 0x20
        imem[8]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);        // 0x20 BEQ r1,r2 (not taken)
        imem[9]  = enc_r(5'd1, 5'd2, 5'd7, 6'h22);         // 0x24 SUB r7,r1,r2
        imem[10] = enc_r(5'd1, 5'd2, 5'd8, 6'h25);         // 0x28 OR  r8,r1,r2
        imem[11] = enc_r(5'd1, 5'd2, 5'd9, 6'h24);         // 0x2C AND r9,r1,r2
        imem[12] = {6'h02, 26'h50};                        // 0x30 J -> 0x140
        imem[80] = enc_i(6'h2B, 5'd0, 5'd7, 16'd24);       // 0x140 SW r7,24(r0)
        imem[81] = enc_i(6'h2B, 5'd0, 5'd8, 16'd28);       // 0x144 SW r8,28(r0)
        imem[82] = enc_i(6'h2B, 5'd0, 5'd9, 16'd32);       // 0x148 SW r9,32(r0)
        imem[83] = 32'hFC00_0000;                          // 0x14C opcode 0x3F
        imem[84] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);     // 0x150 BEQ r1,r1,-1

        repeat (2) @(negedge clk);
        chk("rst_pc", pc_dbg, 32'h100);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h100);

        step("addi_r1", 4, 32'h104);
        step("addi_r2", 4, 32'h108);
        step("add_r3", 4, 32'h10C);
        step("slt_r4", 4, 32'h110);
        wait_cycles = 3;
        step("sw_r3", 10, 32'h114);
        chk_store("sw_r3", 32'h8, 32'd2);
        step("lw_r5", 11, 32'h118);
        chk("wait_stable", stab_err, 32'd0);
        wait_cycles = 0;
        step("sw_r5", 4, 32'h11C);
        chk_store("sw_r5", 32'hC, 32'd2);
        step("sw_r4", 4, 32'h120);
        chk_store("sw_r4", 32'h10, 32'd1);
        step("addi_r0", 4, 32'h124);
        step("add_r6", 4, 32'h128);
        step("sw_r6", 4, 32'h12C);
        chk_store("sw_r6", 32'h14, 32'd0);
        step("j_20", 2, 32'h20);
        step("beq_ne", 3, 32'h24);
        step("sub_r7", 4, 32'h28);
        step("or_r8", 4, 32'h2C);
        step("and_r9", 4, 32'h30);
        step("j_140", 2, 32'h140);
        step("sw_r7", 4, 32'h144);
        chk_store("sw_r7", 32'h18, 32'd8);
        step("sw_r8", 4, 32'h148);
        chk_store("sw_r8", 32'h1C, 32'hFFFF_FFFD);
        step("sw_r9", 4, 32'h14C);
        chk_store("sw_r9", 32'h20, 32'd5);
        chk("store_count", wr_cnt, 32'd7);

`ifdef MIPS_ILLEGAL_TRAP_EN
        n = 0;
        rcnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (retire === 1'b1) rcnt++;
        end while (halted !== 1'b1 && n < 10);
        chk("trap_halted", {31'd0, halted}, 32'd1);
        chk("trap_cycles", n, 32'd3);
        chk("trap_no_retire", rcnt, 32'd0);
        chk("trap_pc", pc_dbg, 32'h150);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || retire !== 1'b0) reqs++;
        end
        chk("halt_quiet", reqs, 32'd0);
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        $display("trap: halted at pc %h", pc_dbg);
`else
        step("illegal_nop", 3, 32'h150);
        chk("nop_no_store", wr_cnt, 32'd7);
        step("beq_self1", 3, 32'h150);
        step("beq_self2", 3, 32'h150);
`endif

        // reset recovery, then a self-loop at the reset vector
        rst = 1'b1;
        imem[64] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);     // 0x100 BEQ r0,r0,-1
        repeat (2) @(negedge clk);
        chk("rerst_halted", {31'd0, halted}, 32'd0);
        chk("rerst_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rerst_addr", mem_addr, 32'h100);
        chk("rerst_reqon", {31'd0, mem_req}, 32'd1);
        step("beq_loop1", 3, 32'h100);
        step("beq_loop2", 3, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
